// File: rtl/parity_serial_rx.sv
// parity_serial_rx: asynchronous serial receiver for the parity-protected byte link.
// Frame is start, 8 data bits LSB first, one parity bit, one stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (4..65535)
//   PARITY_ODD    0 = even parity, 1 = odd parity
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset
//   rx_in         serial line, idles high, asynchronous to clk
//   data_out      last received byte, held until the next data_valid
//   data_valid    one-cycle pulse marking data_out and both flags as updated
//   parity_error  parity check result of the last frame
//   frame_error   stop bit of the last frame sampled low
//   busy          high whenever the receiver is not idle

module parity_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int          HALF     = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        p;

    // Two-flop synchronizer; resets to the idle line level so reset
    // release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            p            <= 1'b0;
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                // Half a bit after the edge: confirm the start bit is
                // still low, otherwise drop it as a glitch.
                START: begin
                    if (tick_cnt == HALF_END) begin
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (tick_cnt == BIT_END) begin
                        tick_cnt       <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state   <= PARITY;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == BIT_END) begin
                        tick_cnt <= '0;
                        p        <= rx_s;
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                // Publish the frame at the stop sample. A low stop bit
                // parks in WAIT_HIGH so a stuck line gives one frame only.
                STOP: begin
                    if (tick_cnt == BIT_END) begin
                        tick_cnt     <= '0;
                        data_out     <= shreg;
                        parity_error <= (^shreg) ^ p ^ PARITY_ODD;
                        frame_error  <= ~rx_s;
                        data_valid   <= 1'b1;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/parity_serial_rx.md
# parity_serial_rx

Serial receiver for the parity-protected byte link. It samples a single-wire asynchronous frame: start bit, 8 data bits LSB first, one parity bit, one stop bit. It returns the byte together with a parity-error flag and a framing-error flag. It is the receiving end of the serial transmit path that carries a byte plus its generated parity bit. It sits between the line pin and the downstream byte consumer.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Legal values are 4 to 65535.
- `PARITY_ODD`, default 0: 0 selects even parity (the XOR of the data bits and the parity bit must be 0). 1 selects odd parity (the XOR must be 1).
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rx_in`  in  1: serial line. It idles high and is asynchronous to `clk`.
- `data_out`  out  8: last received byte. It holds until the next `data_valid`.
- `data_valid`  out  1: one-cycle pulse. It marks `data_out`, `parity_error` and `frame_error` as updated.
- `parity_error`  out  1: parity check result for the last frame. It holds until the next `data_valid`.
- `frame_error`  out  1: set when the stop bit of the last frame sampled low. It holds until the next `data_valid`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Input path: `rx_in` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s` only.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Counters:
  - `tick_cnt` counts from 0 to CLKS_PER_BIT-1, with half period H = CLKS_PER_BIT/2 (integer division).
  - `bit_idx` runs from 0 to 7.
- IDLE: when `rx_s`==0, go to START and load `tick_cnt`=0.
- START: count to H-1. At the sample point:
  - If `rx_s`==0, go to DATA with `bit_idx`=0.
  - If `rx_s`==1, treat it as a glitch or false start. Return to IDLE with no pulse and no flag change.
- DATA:
  - Sample every CLKS_PER_BIT cycles after the start sample.
  - Shift into `data[bit_idx]`, LSB first.
  - After bit 7, go to PARITY.
- PARITY: sample one bit period later and store it as `p`.
- STOP: sample one bit period later. Then:
  - Load `data_out`.
  - Set `parity_error` = (^data) ^ p ^ PARITY_ODD.
  - Set `frame_error` = ~`rx_s`.
  - Pulse `data_valid`.
  - If the stop bit was high, go to IDLE. If it was low, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. A stuck-low line therefore never produces back-to-back phantom frames.
- Simultaneous events: a new falling edge during STOP is not detected until IDLE. A frame whose start edge follows the stop sample by at least 1 cycle must be received correctly.
- Reset values:
  - State IDLE.
  - All counters 0.
  - `data_out`=8'h00.
  - `data_valid`=0, `parity_error`=0, `frame_error`=0, `busy`=0.
  - Synchronizer flops 1.
- Reset mid-frame: return to IDLE immediately with all outputs at their reset values. A partial frame never produces `data_valid`.

## Timing
- t0 is the first cycle in IDLE with `rx_s`==0. This is 2 to 3 clk after the `rx_in` falling edge, because of the synchronizer.
- Start sample: t0+H.
- Data bit i sample: t0+H+(i+1)·CLKS_PER_BIT.
- Parity sample: t0+H+9·CLKS_PER_BIT.
- Stop sample: t0+H+10·CLKS_PER_BIT.
- `data_valid`: high exactly one cycle, registered, in the cycle after the stop sample. `data_out` and both flags are valid in that same cycle.
- `busy`: rises at t0+1 and falls together with the `data_valid` pulse. On a stop-bit error it falls instead when WAIT_HIGH exits.
- Sampling is at mid-bit, so the receiver tolerates a ±(H-1)-cycle edge misalignment.
- Minimum frame spacing for full throughput is 11·CLKS_PER_BIT cycles, with no extra idle required.

## Test plan
- Even parity, CLKS_PER_BIT=16: send byte 8'hA5 with p=0 and stop=1. Required: `data_valid` pulses once with `data_out`=8'hA5, `parity_error`=0 and `frame_error`=0, 1 cycle after the stop sample.
- Parity fault: send 8'h3C with p=1 in even mode. Required: `data_out`=8'h3C and `parity_error`=1. Repeat with PARITY_ODD=1 and 8'h01, p=0. Required: `parity_error`=0.
- Framing fault: send 8'hFF with the stop bit low and the line held low for 40 more cycles, then released high. Required: `frame_error`=1, no second `data_valid`, and `busy` falls only after the line returns high.
- False start: drive `rx_in` low for 5 cycles, then high. Required: no `data_valid`, flags unchanged, and `busy` drops back to 0 within H+3 cycles.
- Back-to-back frames: 8'h00 then 8'h81, with zero idle between them. Required: two `data_valid` pulses 11·16 cycles apart, carrying the correct bytes with both flags 0.
- Reset mid-frame: assert `rst` during DATA bit 4 of 8'h55, release it, then send 8'h96. Required: outputs return to reset values, no pulse for the aborted frame, and exactly one `data_valid` with 8'h96.
